// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing generator with frame-buffer latency
// compensation, per-axis sync polarity, colour bit-replication and
// registered pixel outputs with data-enable / line-start / frame-start markers.
module vga_timing_ctrl #(
    parameter int H_VIS_AREA_PXL            = 800,
    parameter int H_FRONT_PORCH_PXL         = 40,
    parameter int H_SYNC_PULSE_PXL          = 128,
    parameter int H_BACK_PORCH_PXL          = 88,
    parameter int H_NUM_BITS                = 11,
    parameter int V_VIS_AREA_PXL            = 600,
    parameter int V_FRONT_PORCH_PXL         = 1,
    parameter int V_SYNC_PULSE_PXL          = 4,
    parameter int V_BACK_PORCH_PXL          = 23,
    parameter int V_NUM_BITS                = 10,
    parameter int H_SYNC_ACTIVE             = 0,
    parameter int V_SYNC_ACTIVE             = 0,
    parameter int FRAME_BUFFER_READ_LATENCY = 1,
    parameter int RED_CHANNEL_WIDTH         = 3,
    parameter int GREEN_CHANNEL_WIDTH       = 3,
    parameter int BLUE_CHANNEL_WIDTH        = 2,
    parameter int OUT_CHANNEL_WIDTH         = 4
) (
    input  logic                                                                  clk,
    input  logic                                                                  reset,
    input  logic                                                                  pxl_en,
    input  logic [RED_CHANNEL_WIDTH+GREEN_CHANNEL_WIDTH+BLUE_CHANNEL_WIDTH-1:0]   color,
    output logic [H_NUM_BITS-1:0]                                                 h_pxl_count,
    output logic [V_NUM_BITS-1:0]                                                 v_pxl_count,
    output logic [OUT_CHANNEL_WIDTH-1:0]                                          red,
    output logic [OUT_CHANNEL_WIDTH-1:0]                                          green,
    output logic [OUT_CHANNEL_WIDTH-1:0]                                          blue,
    output logic                                                                  h_sync,
    output logic                                                                  v_sync,
    output logic                                                                  de,
    output logic                                                                  line_start,
    output logic                                                                  frame_start
);

    localparam int H_TOTAL = H_VIS_AREA_PXL + H_FRONT_PORCH_PXL + H_SYNC_PULSE_PXL + H_BACK_PORCH_PXL;
    localparam int V_TOTAL = V_VIS_AREA_PXL + V_FRONT_PORCH_PXL + V_SYNC_PULSE_PXL + V_BACK_PORCH_PXL;
    localparam int LAT     = FRAME_BUFFER_READ_LATENCY;
    localparam int RW      = RED_CHANNEL_WIDTH;
    localparam int GW      = GREEN_CHANNEL_WIDTH;
    localparam int BW      = BLUE_CHANNEL_WIDTH;
    localparam int CW      = RW + GW + BW;
    localparam int OW      = OUT_CHANNEL_WIDTH;

    // Comparisons are done one bit wider than the counters so a sync window
    // that ends exactly at 2**N (zero back porch) does not truncate to zero.
    localparam int HX = H_NUM_BITS + 1;
    localparam int VX = V_NUM_BITS + 1;

    localparam logic [H_NUM_BITS-1:0] H_LAST       = H_NUM_BITS'(H_TOTAL - 1);
    localparam logic [V_NUM_BITS-1:0] V_LAST       = V_NUM_BITS'(V_TOTAL - 1);
    localparam logic [HX-1:0]         H_VIS_END    = HX'(H_VIS_AREA_PXL);
    localparam logic [HX-1:0]         H_SYNC_START = HX'(H_VIS_AREA_PXL + H_FRONT_PORCH_PXL);
    localparam logic [HX-1:0]         H_SYNC_END   = HX'(H_VIS_AREA_PXL + H_FRONT_PORCH_PXL + H_SYNC_PULSE_PXL);
    localparam logic [VX-1:0]         V_VIS_END    = VX'(V_VIS_AREA_PXL);
    localparam logic [VX-1:0]         V_SYNC_START = VX'(V_VIS_AREA_PXL + V_FRONT_PORCH_PXL);
    localparam logic [VX-1:0]         V_SYNC_END   = VX'(V_VIS_AREA_PXL + V_FRONT_PORCH_PXL + V_SYNC_PULSE_PXL);

    localparam logic H_ACT = (H_SYNC_ACTIVE != 0);
    localparam logic V_ACT = (V_SYNC_ACTIVE != 0);

    // Reject geometries and colour formats the datapath cannot represent.
    generate
        if (H_TOTAL > 2**H_NUM_BITS) begin : g_h_width_err
            $error("vga_timing_ctrl: H_TOTAL does not fit in H_NUM_BITS");
        end
        if (V_TOTAL > 2**V_NUM_BITS) begin : g_v_width_err
            $error("vga_timing_ctrl: V_TOTAL does not fit in V_NUM_BITS");
        end
        if (RW < 1 || RW > OW) begin : g_red_width_err
            $error("vga_timing_ctrl: RED_CHANNEL_WIDTH must be 1..OUT_CHANNEL_WIDTH");
        end
        if (GW < 1 || GW > OW) begin : g_green_width_err
            $error("vga_timing_ctrl: GREEN_CHANNEL_WIDTH must be 1..OUT_CHANNEL_WIDTH");
        end
        if (BW < 1 || BW > OW) begin : g_blue_width_err
            $error("vga_timing_ctrl: BLUE_CHANNEL_WIDTH must be 1..OUT_CHANNEL_WIDTH");
        end
        if (LAT < 0) begin : g_lat_err
            $error("vga_timing_ctrl: FRAME_BUFFER_READ_LATENCY must not be negative");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [H_NUM_BITS-1:0] h_count;
    logic [V_NUM_BITS-1:0] v_count;
    logic                  h_wrap;
    logic                  v_wrap;

    assign h_wrap = (h_count == H_LAST);
    assign v_wrap = (v_count == V_LAST);

    // Advance the raster position once per enabled pixel; v steps on h wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pxl_en) begin
            if (h_wrap) begin
                h_count <= '0;
                if (v_wrap) begin
                    v_count <= '0;
                end else begin
                    v_count <= v_count + V_NUM_BITS'(1);
                end
            end else begin
                h_count <= h_count + H_NUM_BITS'(1);
            end
        end
    end

    assign h_pxl_count = h_count;
    assign v_pxl_count = v_count;

    // ------------------------------------------------------------------
    // Delay line matching the frame-buffer read latency
    // ------------------------------------------------------------------
    logic [H_NUM_BITS-1:0] hd;
    logic [V_NUM_BITS-1:0] vd;
    logic                  dvalid;

    generate
        if (LAT == 0) begin : g_no_delay
            assign hd     = h_count;
            assign vd     = v_count;
            assign dvalid = 1'b1;
        end else begin : g_delay
            logic [H_NUM_BITS-1:0] pipe_h     [LAT];
            logic [V_NUM_BITS-1:0] pipe_v     [LAT];
            logic [LAT-1:0]        pipe_valid;

            // Valid bits restart empty after reset so stale positions never reach the pins.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pipe_valid <= '0;
                end else if (pxl_en) begin
                    pipe_valid[0] <= 1'b1;
                    for (int i = 1; i < LAT; i++) begin
                        pipe_valid[i] <= pipe_valid[i-1];
                    end
                end
            end

            // Position payload shifts alongside the valid bits; it needs no reset.
            always_ff @(posedge clk) begin
                if (pxl_en) begin
                    pipe_h[0] <= h_count;
                    pipe_v[0] <= v_count;
                    for (int i = 1; i < LAT; i++) begin
                        pipe_h[i] <= pipe_h[i-1];
                        pipe_v[i] <= pipe_v[i-1];
                    end
                end
            end

            assign hd     = pipe_h[LAT-1];
            assign vd     = pipe_v[LAT-1];
            assign dvalid = pipe_valid[LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Colour expansion: MSB-first bit replication to the DAC width
    // ------------------------------------------------------------------
    logic [RW-1:0] red_in;
    logic [GW-1:0] green_in;
    logic [BW-1:0] blue_in;
    logic [OW-1:0] red_exp;
    logic [OW-1:0] green_exp;
    logic [OW-1:0] blue_exp;

    assign red_in   = color[CW-1 -: RW];
    assign green_in = color[BW+GW-1 -: GW];
    assign blue_in  = color[BW-1:0];

    generate
        for (genvar k = 0; k < OW; k++) begin : g_expand
            assign red_exp[OW-1-k]   = red_in[RW-1-(k % RW)];
            assign green_exp[OW-1-k] = green_in[GW-1-(k % GW)];
            assign blue_exp[OW-1-k]  = blue_in[BW-1-(k % BW)];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Region decode of the delayed position
    // ------------------------------------------------------------------
    logic [HX-1:0] hd_ext;
    logic [VX-1:0] vd_ext;
    logic          h_in_sync;
    logic          v_in_sync;
    logic          visible;
    logic          at_line_start;
    logic          at_frame_start;

    assign hd_ext = {1'b0, hd};
    assign vd_ext = {1'b0, vd};

    // Classify the delayed pixel into sync window, visible area and markers.
    always_comb begin
        h_in_sync      = (hd_ext >= H_SYNC_START) && (hd_ext < H_SYNC_END);
        v_in_sync      = (vd_ext >= V_SYNC_START) && (vd_ext < V_SYNC_END);
        visible        = (hd_ext < H_VIS_END) && (vd_ext < V_VIS_END);
        at_line_start  = (hd == '0);
        at_frame_start = (hd == '0) && (vd == '0);
    end

    // ------------------------------------------------------------------
    // Registered pin stage
    // ------------------------------------------------------------------

    // Load the pins once per enabled pixel; an unfilled delay line keeps them idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            h_sync      <= ~H_ACT;
            v_sync      <= ~V_ACT;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pxl_en) begin
            if (dvalid) begin
                red         <= visible ? red_exp   : '0;
                green       <= visible ? green_exp : '0;
                blue        <= visible ? blue_exp  : '0;
                h_sync      <= h_in_sync ? H_ACT : ~H_ACT;
                v_sync      <= v_in_sync ? V_ACT : ~V_ACT;
                de          <= visible;
                line_start  <= at_line_start;
                frame_start <= at_frame_start;
            end else begin
                red         <= '0;
                green       <= '0;
                blue        <= '0;
                h_sync      <= ~H_ACT;
                v_sync      <= ~V_ACT;
                de          <= 1'b0;
                line_start  <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: scoreboard bench driving three small-raster instances
// (latency 1 active-low, latency 0 active-high, latency 3 active-low) with
// randomized pixel enables, colours and resets, checked against a model that
// derives every pin from the count of enabled cycles since reset.
module tb_vga_timing_ctrl;

    localparam int HT = 8;   // 4 visible + 1 fp + 2 sync + 1 bp
    localparam int VT = 6;   // 3 visible + 1 fp + 1 sync + 1 bp

    typedef struct packed {
        logic [3:0] h;
        logic [2:0] v;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       pxl_en;
    logic [7:0] color;

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Replicate a w-bit value end to end and keep the top four bits.
    function automatic logic [3:0] expand(input int w, input logic [3:0] c);
        logic [31:0] rep;
        int          n;
        rep = '0;
        n   = (4 + w - 1) / w;
        for (int i = 0; i < n; i++) begin
            rep = (rep << w) | 32'(c);
        end
        return 4'(rep >> (n * w - 4));
    endfunction

    task automatic checkOutput(input string name, input int cfg, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s cfg%0d t=%0t actual=%0h required=%0h", name, cfg, $time, act, req);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [7:0] col);
        @(negedge clk);
        reset  = rst;
        pxl_en = en;
        color  = col;
    endtask

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
            localparam int   LAT  = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
            localparam int   ACTI = (gi == 1) ? 1 : 0;
            localparam logic ACT  = (ACTI != 0);

            logic [3:0] h_cnt;
            logic [2:0] v_cnt;
            logic [3:0] r_o;
            logic [3:0] g_o;
            logic [3:0] b_o;
            logic       hs_o;
            logic       vs_o;
            logic       de_o;
            logic       ls_o;
            logic       fs_o;

            vga_timing_ctrl #(
                .H_VIS_AREA_PXL(4), .H_FRONT_PORCH_PXL(1), .H_SYNC_PULSE_PXL(2), .H_BACK_PORCH_PXL(1),
                .H_NUM_BITS(4),
                .V_VIS_AREA_PXL(3), .V_FRONT_PORCH_PXL(1), .V_SYNC_PULSE_PXL(1), .V_BACK_PORCH_PXL(1),
                .V_NUM_BITS(3),
                .H_SYNC_ACTIVE(ACTI), .V_SYNC_ACTIVE(ACTI),
                .FRAME_BUFFER_READ_LATENCY(LAT),
                .RED_CHANNEL_WIDTH(3), .GREEN_CHANNEL_WIDTH(3), .BLUE_CHANNEL_WIDTH(2),
                .OUT_CHANNEL_WIDTH(4)
            ) dut (
                .clk(clk), .reset(reset), .pxl_en(pxl_en), .color(color),
                .h_pxl_count(h_cnt), .v_pxl_count(v_cnt),
                .red(r_o), .green(g_o), .blue(b_o),
                .h_sync(hs_o), .v_sync(vs_o), .de(de_o),
                .line_start(ls_o), .frame_start(fs_o)
            );

            exp_t q[$];
            exp_t cur;
            exp_t got;
            exp_t e;
            int   st;
            logic started = 1'b0;

            // Expected pins after the st-th enabled edge since reset (st = -1: just reset).
            function automatic exp_t build(input int s, input logic [7:0] col);
                exp_t x;
                int   n, p, hp, vp;
                x = '0;
                x.hs = ~ACT;
                x.vs = ~ACT;
                if (s >= 0) begin
                    n   = s + 1;
                    x.h = 4'(n % HT);
                    x.v = 3'((n / HT) % VT);
                    p   = s - LAT;
                    if (p >= 0) begin
                        hp   = p % HT;
                        vp   = (p / HT) % VT;
                        x.hs = (hp >= 5 && hp < 7) ? ACT : ~ACT;
                        x.vs = (vp == 4) ? ACT : ~ACT;
                        x.de = (hp < 4) && (vp < 3);
                        x.ls = (hp == 0);
                        x.fs = (hp == 0) && (vp == 0);
                        if (x.de) begin
                            x.r = expand(3, {1'b0, col[7:5]});
                            x.g = expand(3, {1'b0, col[4:2]});
                            x.b = expand(2, {2'b00, col[1:0]});
                        end
                    end
                end
                return x;
            endfunction

            // Issue side: every clock edge pushes the pins the model predicts.
            always @(posedge clk) begin
                if (reset) begin
                    st      = -1;
                    started = 1'b1;
                    cur     = build(st, 8'h00);
                    q.push_back(cur);
                end else if (started) begin
                    if (pxl_en) begin
                        st  = st + 1;
                        cur = build(st, color);
                    end
                    q.push_back(cur);
                end
            end

            // Monitor side: after the edge settles, pop a prediction and compare pins.
            always @(posedge clk) begin
                #1;
                if (q.size() > 0) begin
                    e   = q.pop_front();
                    got = '{h: h_cnt, v: v_cnt, r: r_o, g: g_o, b: b_o,
                            hs: hs_o, vs: vs_o, de: de_o, ls: ls_o, fs: fs_o};
                    checkOutput("h_count", gi, int'(got.h), int'(e.h));
                    checkOutput("v_count", gi, int'(got.v), int'(e.v));
                    checkOutput("red", gi, int'(got.r), int'(e.r));
                    checkOutput("green", gi, int'(got.g), int'(e.g));
                    checkOutput("blue", gi, int'(got.b), int'(e.b));
                    checkOutput("h_sync", gi, int'(got.hs), int'(e.hs));
                    checkOutput("v_sync", gi, int'(got.vs), int'(e.vs));
                    checkOutput("de", gi, int'(got.de), int'(e.de));
                    checkOutput("line_start", gi, int'(got.ls), int'(e.ls));
                    checkOutput("frame_start", gi, int'(got.fs), int'(e.fs));
                end
            end
        end
    endgenerate

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        pxl_en = 1'b0;
        color  = 8'h00;

        $display("[TB] reset, reset dominating pxl_en");
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'($urandom));

        $display("[TB] continuous enable, fixed colour 101_011_10 for one frame");
        for (int i = 0; i < 48; i++) applyStimulus(1'b0, 1'b1, 8'b101_011_10);
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));

        $display("[TB] enable held low mid-frame");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'($urandom));

        $display("[TB] enable one cycle in four");
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 200; i++) applyStimulus(1'b0, (i % 4) == 0, 8'($urandom));

        $display("[TB] reset at h=5 v=2");
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 21; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));
        applyStimulus(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));

        $display("[TB] random enable gaps and occasional resets");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 64) == 0, ($urandom % 5) < 3, 8'($urandom));
        end

        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Second-generation VGA timing and pixel-output block. It generates h/v pixel counters for frame-buffer addressing and compensates a parametrised frame-buffer read latency. It outputs registered RGB and sync, so there are no combinational glitches at the pins. New over the first generation: pixel-clock-enable strobe, per-axis sync polarity, bit-replicated colour expansion to any output width, and data-enable / line-start / frame-start markers aligned to the output pixels.

Parameters:
H_VIS_AREA_PXL, 800, visible pixels per line
H_FRONT_PORCH_PXL, 40, h front porch
H_SYNC_PULSE_PXL, 128, h sync width
H_BACK_PORCH_PXL, 88, h back porch
H_NUM_BITS, 11, h counter width; elaboration error if H_TOTAL > 2**H_NUM_BITS
V_VIS_AREA_PXL, 600, visible lines
V_FRONT_PORCH_PXL, 1, v front porch
V_SYNC_PULSE_PXL, 4, v sync width
V_BACK_PORCH_PXL, 23, v back porch
V_NUM_BITS, 10, v counter width; same elaboration check against V_TOTAL
H_SYNC_ACTIVE, 0, level of h_sync during the pulse (0 = active-low)
V_SYNC_ACTIVE, 0, level of v_sync during the pulse
FRAME_BUFFER_READ_LATENCY, 1, enabled cycles from count to valid color; 0 allowed
RED_CHANNEL_WIDTH, 3, input red bits
GREEN_CHANNEL_WIDTH, 3, input green bits
BLUE_CHANNEL_WIDTH, 2, input blue bits
OUT_CHANNEL_WIDTH, 4, DAC bits per channel; each input width must be between 1 and OUT_CHANNEL_WIDTH (elaboration error otherwise)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pxl_en  in  1  pixel-clock enable strobe; all state advances only when high
color  in  R+G+B  packed {red,green,blue} from frame buffer, MSB = red
h_pxl_count  out  H_NUM_BITS  current (undelayed) h count, frame-buffer address
v_pxl_count  out  V_NUM_BITS  current (undelayed) v count
red  out  OUT_CHANNEL_WIDTH  registered red
green  out  OUT_CHANNEL_WIDTH  registered green
blue  out  OUT_CHANNEL_WIDTH  registered blue
h_sync  out  1  registered h sync
v_sync  out  1  registered v sync
de  out  1  registered data-enable, high for visible output pixels
line_start  out  1  high while output pixel h=0 is presented (any line)
frame_start  out  1  high while output pixel (0,0) is presented

Behaviour:
- H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
- Reset (sync, dominates pxl_en): h=v=0. Delay-pipeline valid bits are cleared. red/green/blue=0, de=0, line_start=0, frame_start=0, h_sync=!H_SYNC_ACTIVE, v_sync=!V_SYNC_ACTIVE.
- Counters (on pxl_en only):
  - h increments and wraps H_TOTAL-1 -> 0.
  - v increments only on h wrap, and wraps V_TOTAL-1 -> 0 when h wraps at the same time.
  - pxl_en=0: all registers hold.
- Delay pipeline: FRAME_BUFFER_READ_LATENCY stages carrying {h,v,valid}, shifted on pxl_en. Stage-in valid=1 after reset.
- Output register (updated on pxl_en) for delayed entry (hd,vd,valid):
  - valid=0: hold reset values.
  - valid=1:
    - h_sync = H_SYNC_ACTIVE when H_VIS+H_FP <= hd < H_VIS+H_FP+H_SYNC, else inverse. v_sync uses the same rule on vd.
    - de = (hd < H_VIS) && (vd < V_VIS).
    - RGB = expanded color when de, else 0.
    - line_start = (hd == 0); frame_start = (hd == 0 && vd == 0).
- Latency with pxl_en tied high: count (h,v) presented in cycle t; color must be valid in cycle t+L; pins show that pixel from cycle t+L+1.
- Colour expansion is MSB-first bit replication: output bit (OUT-1-k) = input bit (W-1 - (k mod W)).
  - 3-bit 101 -> 1011; 2-bit 10 -> 1010; 1-bit 1 -> 1111.
  - W == OUT passes through unchanged.
- Reset mid-frame: next enabled cycle restarts at (0,0). Outputs stay blank/inactive until the pipeline refills (L+1 enabled cycles).
- pxl_en irregular (gaps of any length): output sequence is identical to the continuous case, stretched in time.

Test Plan:
- Small timing: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), L=1, pxl_en=1, active-low. Release reset -> h_sync low for 2 cycles starting cycle 7 after release; de high cycles 2-5; line_start every 8 cycles; frame_start every 48 cycles.
- Same config, L=0 and L=3 -> de/sync edges shift to cycles 1 and 4 (respectively) relative to L=0 timing; color sampled exactly L cycles after its count.
- Color width 3/3/2 to OUT=4, color=8'b101_011_10 during visible -> red=1011, green=0110, blue=1010; during blanking with same color -> all 0.
- H_SYNC_ACTIVE=1, V_SYNC_ACTIVE=1 -> h_sync high only in sync window; both idle low after reset.
- pxl_en high 1 of every 4 cycles -> counters/outputs hold between strobes; per-strobe sequence identical to the first scenario.
- Assert reset at h=5,v=2 for 1 cycle -> counters 0 next cycle; outputs blank, de=0, syncs inactive for L+1 enabled cycles; frame_start then asserts with pixel (0,0).
